// File: rtl/led_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package led_pkg;

    // Scan phases: dark, one digit lit, all anodes off between digits.
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        DRIVE = 2'd1,
        GUARD = 2'd2
    } scan_state_e;

    // All segments off (segments are active-low).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] lit;
        case (nib)
            4'h0: lit = 7'h3F;
            4'h1: lit = 7'h06;
            4'h2: lit = 7'h5B;
            4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66;
            4'h5: lit = 7'h6D;
            4'h6: lit = 7'h7D;
            4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F;
            4'h9: lit = 7'h6F;
            4'hA: lit = 7'h77;
            4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39;
            4'hD: lit = 7'h5E;
            4'hE: lit = 7'h79;
            default: lit = 7'h71;
        endcase
        return ~lit;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot timer shared by the DRIVE and GUARD phases. Counts 0..last and
// restarts; tc marks the final cycle of the slot. load forces a restart.
module scan_timer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] last,
    output logic                 tc
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Terminal count and next count value.
    always_comb begin
        tc    = (cnt_q == last);
        cnt_d = (load || tc) ? '0 : cnt_q + CNT_WIDTH'(1);
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a tear-free shadow
// register. Load handshake: a word transfers on a clock edge where
// ld_valid && ld_ready are both 1; ld_ready then stays 0 until the shadow
// has been copied to the displayed value (at the frame boundary, or at
// once while dark) and returns to 1 the cycle after that copy. ld_valid
// while ld_ready is 0 is simply ignored.
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DRIVE_COUNT = 50000,
    parameter int GUARD_COUNT = 500,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    blank_lz,
    input  logic                    ld_valid,
    input  logic [4*NUM_DIGITS-1:0] ld_data,
    output logic                    ld_ready,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output scan_state_e             dbg_state
);

    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic [DIG_W-1:0]        digit_q, digit_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic                    shadow_full_q, shadow_full_d;
    logic                    ld_ready_q, ld_ready_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic                    timer_load;
    logic                    timer_tc;
    logic [CNT_WIDTH-1:0]    timer_last;
    logic                    capture;
    logic                    copy;
    logic                    upper_nz;
    logic                    blanked;
    logic [3:0]              nib;

    assign timer_last = (state_q == GUARD) ? CNT_WIDTH'(GUARD_COUNT - 1)
                                           : CNT_WIDTH'(DRIVE_COUNT - 1);

    scan_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .last (timer_last),
        .tc   (timer_tc)
    );

    // Scan sequencing: next state, digit index and frame boundary.
    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        timer_load   = 1'b0;
        frame_done_d = 1'b0;
        if (!en) begin
            state_d    = OFF;
            digit_d    = '0;
            timer_load = 1'b1;
        end else begin
            case (state_q)
                OFF: begin
                    state_d    = DRIVE;
                    digit_d    = '0;
                    timer_load = 1'b1;
                end
                DRIVE: begin
                    if (timer_tc) begin
                        state_d    = GUARD;
                        timer_load = 1'b1;
                    end
                end
                GUARD: begin
                    if (timer_tc) begin
                        state_d    = DRIVE;
                        timer_load = 1'b1;
                        if (digit_q == LAST_DIGIT) begin
                            digit_d      = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            digit_d = digit_q + DIG_W'(1);
                        end
                    end
                end
                default: begin
                    state_d    = OFF;
                    digit_d    = '0;
                    timer_load = 1'b1;
                end
            endcase
        end
    end

    // Shadow capture and shadow-to-active copy; the two are mutually exclusive.
    always_comb begin
        capture       = ld_valid & ld_ready_q;
        copy          = shadow_full_q & (frame_done_d | (state_q == OFF));
        shadow_d      = capture ? ld_data : shadow_q;
        active_d      = copy ? shadow_q : active_q;
        shadow_full_d = capture | (shadow_full_q & ~copy);
        ld_ready_d    = ~capture & ~shadow_full_q;
    end

    // Output decode from the next state, so a fresh frame shows fresh data.
    always_comb begin
        seg_d    = SEG_OFF;
        an_d     = '1;
        upper_nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(digit_d) && active_d[4*i +: 4] != 4'h0) upper_nz = 1'b1;
        end
        blanked = blank_lz && (digit_d != '0) && !upper_nz;
        nib     = active_d[{digit_d, 2'b00} +: 4];
        if (state_d == DRIVE) begin
            an_d[digit_d] = 1'b0;
            seg_d         = blanked ? SEG_OFF : hex_to_seg(nib);
        end
    end

    // All state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= OFF;
            digit_q       <= '0;
            shadow_q      <= '0;
            active_q      <= '0;
            shadow_full_q <= 1'b0;
            ld_ready_q    <= 1'b1;
            seg_q         <= SEG_OFF;
            an_q          <= '1;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            digit_q       <= digit_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            shadow_full_q <= shadow_full_d;
            ld_ready_q    <= ld_ready_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign ld_ready   = ld_ready_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a frame-position model of the display.
module tb_led_scan_ctrl;
    import led_pkg::*;

    localparam int N     = 4;
    localparam int DC    = 4;
    localparam int GC    = 1;
    localparam int SLOT  = DC + GC;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        blank_lz;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;
    scan_state_e dbg_state;

    led_scan_ctrl #(
        .NUM_DIGITS  (N),
        .DRIVE_COUNT (DC),
        .GUARD_COUNT (GC),
        .CNT_WIDTH   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .blank_lz   (blank_lz),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;

    // Active-high segment patterns for hex 0..F.
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: scan position in the frame plus handshake bookkeeping.
    bit          m_on;
    int          m_pos;
    bit          m_full;
    bit          m_ready;
    logic [15:0] m_shadow;
    logic [15:0] m_active;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    bit          e_fd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] digit_seg(input logic [15:0] val, input int d, input bit blz);
        logic [3:0] nib;
        nib = val[4*d +: 4];
        if (blz && d > 0 && (val >> (4*d)) == 16'h0) return 7'h7F;
        return ~seg_tab[nib];
    endfunction

    task automatic model_reset();
        m_on = 0; m_pos = 0; m_full = 0; m_ready = 1;
        m_shadow = '0; m_active = '0;
        e_seg = 7'h7F; e_an = 4'hF; e_fd = 0;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        bit was_off, cap, fd, cp;
        int d;
        was_off = !m_on;
        cap     = ld_valid && m_ready;
        fd      = 0;
        if (!en) begin
            m_on = 0; m_pos = 0;
        end else if (!m_on) begin
            m_on = 1; m_pos = 0;
        end else if (m_pos == FRAME - 1) begin
            m_pos = 0; fd = 1;
        end else begin
            m_pos++;
        end
        cp = m_full && (fd || was_off);
        if (cp) m_active = m_shadow;
        m_ready = cap ? 1'b0 : !m_full;
        m_full  = cap || (m_full && !cp);
        if (cap) m_shadow = ld_data;
        e_fd  = fd;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        if (m_on && (m_pos % SLOT) < DC) begin
            d     = m_pos / SLOT;
            e_an  = ~(4'b0001 << d);
            e_seg = digit_seg(m_active, d, blank_lz);
        end
    endtask

    // One clock with full output comparison against the model.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("an", an, e_an);
        chk("seg", seg, e_seg);
        chk("frame_done", frame_done, e_fd);
        chk("ld_ready", ld_ready, m_ready);
        chk("state_off", dbg_state == OFF, !m_on);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_fd();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2 * FRAME + 5; i++) begin
            step();
            if (frame_done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $error("FAIL wait_fd timeout got=0 exp=1");
        end
    endtask

    task automatic load(input logic [15:0] v);
        bit ok;
        ok       = 0;
        ld_valid = 1'b1;
        ld_data  = v;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (ld_ready) begin
                step();
                ok = 1;
                break;
            end
            step();
        end
        ld_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $error("FAIL load timeout got=0 exp=1");
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; blank_lz = 1'b0; ld_valid = 1'b0; ld_data = '0;
        model_reset();
        #12;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_ready", ld_ready, 1'b1);
        chk("rst_fd", frame_done, 1'b0);
        chk("rst_state", dbg_state, OFF);
        #10;
        rst = 1'b0;

        // Basic scan of 12AF.
        en = 1'b1; ld_valid = 1'b1; ld_data = 16'h12AF;
        step();
        ld_valid = 1'b0;
        chk("t1_first_seg", seg, 7'h40);
        chk("t1_first_an", an, 4'b1110);
        wait_fd();
        chk("t1_d0_an", an, 4'b1110);
        chk("t1_d0_seg", seg, 7'h0E);
        chk("t1_fd_ready", ld_ready, 1'b0);
        step();
        chk("t1_ready_back", ld_ready, 1'b1);
        steps(4);
        chk("t1_d1_an", an, 4'b1101);
        chk("t1_d1_seg", seg, 7'h08);
        steps(4);
        chk("t1_g1_an", an, 4'b1111);
        step();
        chk("t1_d2_an", an, 4'b1011);
        chk("t1_d2_seg", seg, 7'h24);
        steps(5);
        chk("t1_d3_an", an, 4'b0111);
        chk("t1_d3_seg", seg, 7'h79);
        steps(5);
        chk("t1_period", frame_done, 1'b1);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        load(16'h0005);
        wait_fd();
        chk("t2_d0_seg", seg, 7'h12);
        steps(5);
        chk("t2_d1_an", an, 4'b1101);
        chk("t2_d1_seg", seg, 7'h7F);
        steps(10);
        chk("t2_d3_an", an, 4'b0111);
        chk("t2_d3_seg", seg, 7'h7F);
        load(16'h0000);
        wait_fd();
        chk("t2_zero_seg", seg, 7'h40);
        steps(5);
        chk("t2_zero_d1", seg, 7'h7F);

        // Mid-frame load, then a held second value.
        blank_lz = 1'b0;
        steps(2);
        load(16'hBEEF);
        ld_valid = 1'b1; ld_data = 16'h1111;
        for (int i = 0; i < FRAME + 2; i++) begin
            step();
            chk("t3_ready_low", ld_ready, 1'b0);
            if (!frame_done) chk("t3_old_seg", seg == 7'h7F || seg == 7'h40, 1'b1);
            if (frame_done) break;
        end
        chk("t3_fd", frame_done, 1'b1);
        chk("t3_new_seg", seg, 7'h0E);
        step();
        chk("t3_ready_back", ld_ready, 1'b1);
        step();
        chk("t3_recapture", ld_ready, 1'b0);
        ld_valid = 1'b0;
        steps(3);
        chk("t3_d1_seg", seg, 7'h06);
        wait_fd();
        chk("t3_1111_seg", seg, 7'h79);

        // Disable during digit 2, then restart.
        steps(10);
        chk("t4_d2_an", an, 4'b1011);
        en = 1'b0;
        step();
        chk("t4_dark_an", an, 4'hF);
        chk("t4_dark_seg", seg, 7'h7F);
        steps(2);
        en = 1'b1;
        step();
        chk("t4_restart_an", an, 4'b1110);
        chk("t4_restart_seg", seg, 7'h79);

        // Load while dark.
        en = 1'b0;
        step();
        load(16'h3C3C);
        steps(2);
        chk("t5_ready", ld_ready, 1'b1);
        en = 1'b1;
        step();
        chk("t5_d0_seg", seg, 7'h46);
        steps(5);
        chk("t5_d1_seg", seg, 7'h30);

        // Reset during guard with a pending value.
        load(16'h5555);
        steps(3);
        chk("t6_guard_an", an, 4'hF);
        chk("t6_pending", ld_ready, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6_rst_an", an, 4'hF);
        chk("t6_rst_seg", seg, 7'h7F);
        chk("t6_rst_ready", ld_ready, 1'b1);
        chk("t6_rst_state", dbg_state, OFF);
        #12;
        rst = 1'b0;
        step();
        chk("t6_d0_an", an, 4'b1110);
        chk("t6_d0_seg", seg, 7'h40);
        steps(5);
        chk("t6_d1_seg", seg, 7'h40);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 39) == 0) en = !en;
            if ($urandom_range(0, 49) == 0) blank_lz = !blank_lz;
            ld_valid = ($urandom_range(0, 3) == 0);
            ld_data  = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
